decode_stage_p: RTL
===================

# decode_stage_p

Parametrised, pipelined successor to the single-cycle decode block. It owns the 8-entry general register file, the immediate extender, write-back bypass and a load-use interlock, and it registers everything into an ID/EX pipeline register with a valid/ready handshake. Fetch drives it from upstream and the execute stage consumes it downstream. Control decoding comes from the existing `instruction_ctl` via the `ctl_*` inputs.

## Interface
- `DATA_W`, 16, register and datapath width; must be ≥ 16.
- `BYPASS`, 1, 1 = a same-cycle write-back is forwarded to the read ports; 0 = the read returns the old value.
- `clk  input  1  clock; all state is updated on the rising edge`
- `rst  input  1  asynchronous, active-low reset`
- `in_valid  input  1  instruction presented`
- `in_ready  output  1  stage accepts the instruction this cycle`
- `instr  input  16  instruction; rs=[10:8], rt=[7:5], rd=[4:2]`
- `ctl_regdst  input  2  destination select: 0=rs, 1=rt, 2=rd, 3=illegal`
- `ctl_reg_wr, ctl_mem_rd, ctl_mem_wr, ctl_alu_src  input  1 each  control bits from the controller`
- `ctl_alu_op  input  3  ALU operation`
- `ctl_imm_mode  input  2  immediate format: 0=sext[4:0], 1=zext[4:0], 2=sext[7:0], 3=sext[10:0]`
- `flush  input  1  kill the contents of the ID/EX register and the incoming instruction`
- `wb_en  input  1  register-file write enable`
- `wb_sel  input  3  register-file write address`
- `wb_data  input  DATA_W  register-file write data`
- `out_valid  output  1  ID/EX register holds a valid instruction`
- `out_ready  input  1  execute stage accepts`
- `out_rd1, out_rd2  output  DATA_W  registered operands; out_rd2 = immediate when alu_src=1`
- `out_imm  output  DATA_W  registered extended immediate`
- `out_dest  output  3  registered destination register`
- `out_reg_wr, out_mem_rd, out_mem_wr  output  1  registered controls`
- `out_alu_op  output  3  registered ALU operation`
- `out_err  output  1  registered illegal-regdst flag`

## Operation
- **Register file:** 8 × DATA_W registers, all cleared on reset. r0 is an ordinary register.
  - Writes happen on the edge when `wb_en`=1.
  - Reads are combinational on rs and rt.
  - With `BYPASS`=1, a read of `wb_sel` while `wb_en`=1 returns `wb_data`.
- **Immediate:** extended to DATA_W per `ctl_imm_mode`.
- **Destination:** chosen by `ctl_regdst`. Value 3 sets `err`, forces `reg_wr`=0 and uses dest=rd. The instruction still flows down the pipeline.
- **Load-use hazard** (`haz`) is true when all of these hold:
  - `out_valid` and `out_mem_rd` and `out_reg_wr`, and
  - `out_dest` == rs, or (`out_dest` == rt and `ctl_alu_src`=0), and
  - `in_valid`.
- **Handshake:**
  - `adv` = `out_ready` | ~`out_valid`.
  - `in_ready` = `adv` & ~`haz`.
  - An instruction transfers in when `in_valid` & `in_ready`.
- **ID/EX update on each edge, in priority order:**
  1. `flush` → `out_valid`=0. The incoming instruction is discarded, but `in_ready` still obeys the rule above, so fetch sees it consumed.
  2. `adv` & `haz` → a bubble is loaded (`out_valid`=0, controls 0). The instruction is held upstream.
  3. `adv` & `in_valid` → the decoded instruction is loaded and `out_valid`=1.
  4. `adv` & ~`in_valid` → `out_valid`=0.
  5. ~`adv` → hold all outputs.
- A bubble's `out_reg_wr`, `out_mem_rd`, `out_mem_wr` and `out_err` are always 0.

## Timing
- **Reset:** while `rst`=0:
  - all `out_*` = 0 and all registers = 0;
  - `in_ready`=0 (forced).
  - After release, `in_ready` follows the handshake rules from the first edge.
- **Latency:** 1 cycle from acceptance to `out_valid`. Full throughput of 1 instruction/cycle with no hazard.
- **Load-use stall:** exactly 1 bubble. The consumer is accepted on the edge after the load leaves ID/EX.
- **Simultaneous events:**
  - `flush` with `haz`: flush wins, and `in_ready` stays 0 that cycle.
  - Write-back to a register being read in the same cycle: governed by `BYPASS`.
- **Backpressure:** when `out_ready`=0 and `out_valid`=1, outputs are stable and `in_ready`=0.

## Test plan
- **Reset mid-stream:** drop `rst` while `out_valid`=1 → `out_valid`, `out_rd1`, `out_dest` go to 0 immediately (asynchronously), `in_ready`=0; after release, all registers read 0.
- **Write/read and bypass:** write r3=0x1234, then decode rs=3 → `out_rd1`=0x1234 one cycle later. Same-cycle write r5=0xBEEF with rt=5 → `out_rd2`=0xBEEF for `BYPASS`=1, and the old value for `BYPASS`=0.
- **Immediates:** `instr[10:0]`=0x7F0, `imm_mode`=3 → `out_imm`=0xFFF0. `[4:0]`=0x10: mode 0 → 0xFFF0, mode 1 → 0x0010. Repeat at `DATA_W`=32 with correct sign fill.
- **Load-use:** load with dest r2, then an add reading r2 → exactly one bubble (`out_valid`=0 for one cycle), `in_ready`=0 for one cycle, then the add issues. The same sequence with the second instruction using `alu_src`=1 and rt=r2 gives no stall.
- **Backpressure and flush:** hold `out_ready`=0 for 3 cycles → outputs stable and `in_ready`=0. Assert `flush` together with `in_valid` → `out_valid`=0 next cycle and the instruction does not appear.
- **Illegal regdst:** `ctl_regdst`=3 with `ctl_reg_wr`=1 → `out_err`=1, `out_reg_wr`=0, `out_valid`=1.

Source files
------------

// File: rtl/decode_stage_p.sv
// Pipelined decode stage: 8-entry register file, immediate extender, write-back
// bypass, load-use interlock and a valid/ready ID/EX register.
module decode_stage_p #(
  parameter int DATA_W = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [1:0]        ctl_regdst,
  input  logic              ctl_reg_wr,
  input  logic              ctl_mem_rd,
  input  logic              ctl_mem_wr,
  input  logic              ctl_alu_src,
  input  logic [2:0]        ctl_alu_op,
  input  logic [1:0]        ctl_imm_mode,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_dest,
  output logic              out_reg_wr,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [2:0]        out_alu_op,
  output logic              out_err
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [2:0]        dest;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [2:0]        alu_op;
    logic              err;
  } idex_t;

  logic [DATA_W-1:0] rf [8];
  logic [2:0]        rs, rt, rd;
  logic [DATA_W-1:0] rd1, rd2, rt_val, imm;
  logic [2:0]        dest;
  logic              err;
  logic              haz, adv;
  logic              vld;
  idex_t             q, d;
  logic              unused_instr;

  assign rs = instr[10:8];
  assign rt = instr[7:5];
  assign rd = instr[4:2];
  assign unused_instr = ^instr[15:11];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_sel] <= wb_data;
    end
  end

  // Bypass lets a result written this edge reach an instruction decoded this cycle.
  assign rd1    = (BYPASS && wb_en && (wb_sel == rs)) ? wb_data : rf[rs];
  assign rt_val = (BYPASS && wb_en && (wb_sel == rt)) ? wb_data : rf[rt];
  assign rd2    = ctl_alu_src ? imm : rt_val;

  always_comb begin
    imm = '0;
    case (ctl_imm_mode)
      2'd0:    imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
      2'd1:    imm = {{(DATA_W-5){1'b0}}, instr[4:0]};
      2'd2:    imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      default: imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
    endcase
  end

  always_comb begin
    err  = 1'b0;
    dest = rd;
    case (ctl_regdst)
      2'd0:    dest = rs;
      2'd1:    dest = rt;
      2'd2:    dest = rd;
      default: err  = 1'b1;
    endcase
  end

  always_comb begin
    d        = '0;
    d.rd1    = rd1;
    d.rd2    = rd2;
    d.imm    = imm;
    d.dest   = dest;
    d.reg_wr = ctl_reg_wr & ~err;
    d.mem_rd = ctl_mem_rd;
    d.mem_wr = ctl_mem_wr;
    d.alu_op = ctl_alu_op;
    d.err    = err;
  end

  // Load in ID/EX whose result is needed by the incoming instruction's register operands.
  assign haz = vld & q.mem_rd & q.reg_wr & in_valid &
               ((q.dest == rs) | ((q.dest == rt) & ~ctl_alu_src));
  assign adv      = out_ready | ~vld;
  assign in_ready = rst & adv & ~haz;

  function automatic idex_t bubble(input idex_t x);
    idex_t b;
    b        = x;
    b.reg_wr = 1'b0;
    b.mem_rd = 1'b0;
    b.mem_wr = 1'b0;
    b.alu_op = 3'd0;
    b.err    = 1'b0;
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      vld <= 1'b0;
      q   <= bubble(q);
    end else if (adv) begin
      if (haz || !in_valid) begin
        vld <= 1'b0;
        q   <= bubble(q);
      end else begin
        vld <= 1'b1;
        q   <= d;
      end
    end
  end

  assign out_valid  = vld;
  assign out_rd1    = q.rd1;
  assign out_rd2    = q.rd2;
  assign out_imm    = q.imm;
  assign out_dest   = q.dest;
  assign out_reg_wr = q.reg_wr;
  assign out_mem_rd = q.mem_rd;
  assign out_mem_wr = q.mem_wr;
  assign out_alu_op = q.alu_op;
  assign out_err    = q.err;

endmodule
